// File: rtl/prim_mux2_pkg.sv
// prim_mux2_pkg: select encodings and the per-bit 2:1 truth table.
// PRIM_MUX2_XPROP_EN selects simulation-only X semantics for an unknown select.
package prim_mux2_pkg;
    localparam logic PRIM_MUX2_SEL_IN1 = 1'b1;
    localparam logic PRIM_MUX2_SEL_IN0 = 1'b0;

    function automatic logic mux2_bit(input logic in1, input logic in0, input logic sel);
`ifdef PRIM_MUX2_XPROP_EN
        if (sel === PRIM_MUX2_SEL_IN1) return in1;
        if (sel === PRIM_MUX2_SEL_IN0) return in0;
        // Unknown select: only an agreeing pair of ones resolves, matching the legacy table cell.
        return (in1 === 1'b1 && in0 === 1'b1) ? 1'b1 : 1'bx;
`else
        return (sel == PRIM_MUX2_SEL_IN1) ? in1 : in0;
`endif
    endfunction
endpackage

// File: rtl/prim_mux2_bit.sv
// prim_mux2_bit: single combinational 2:1 select cell built on mux2_bit.
module prim_mux2_bit
    import prim_mux2_pkg::*;
(
    input  logic in1,
    input  logic in0,
    input  logic sel,
    output logic out
);
    assign out = mux2_bit(in1, in0, sel);
endmodule

// File: rtl/prim_mux2_core.sv
// prim_mux2_core: WIDTH-bit 2:1 selector with combinational and one-cycle registered outputs.
// PRIM_MUX2_XPROP_EN also propagates an unknown in_valid into the output register.
module prim_mux2_core
    import prim_mux2_pkg::*;
#(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in0,
    input  logic             select,
    output logic [WIDTH-1:0] out_comb,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);
    logic [WIDTH-1:0] r_out;
    logic             r_valid;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        prim_mux2_bit u_bit (
            .in1 (in1[g]),
            .in0 (in0[g]),
            .sel (select),
            .out (out_comb[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= RESET_VAL;
            r_valid <= 1'b0;
        end
`ifdef PRIM_MUX2_XPROP_EN
        else if ($isunknown(in_valid)) begin
            r_out   <= 'x;
            r_valid <= 1'bx;
        end
`endif
        else begin
            r_valid <= in_valid;
            if (in_valid) r_out <= out_comb;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_prim_mux2_core.sv
// tb_prim_mux2_core: directed vectors with a queued scoreboard on an 8-bit and a 1-bit instance.
module tb_prim_mux2_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in1, in0;
    logic       select;
    logic [7:0] out_comb8, out8;
    logic       out_valid8;
    logic       out_comb1, out1, out_valid1;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } exp_t;
    exp_t q[$];

    typedef struct packed {
        logic       r;
        logic       v;
        logic [7:0] i1;
        logic [7:0] i0;
        logic       s;
        logic [7:0] comb;
        logic [7:0] o;
        logic       ov;
    } vec_t;

    always #5 clk = ~clk;

    prim_mux2_core #(.WIDTH(8), .RESET_VAL(8'h5A)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in0       (in0),
        .select    (select),
        .out_comb  (out_comb8),
        .out       (out8),
        .out_valid (out_valid8)
    );

    // The 1-bit instance sees bit 0 of the shared stimulus, so its expectation is bit 0 of the byte's.
    prim_mux2_core #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1[0]),
        .in0       (in0[0]),
        .select    (select),
        .out_comb  (out_comb1),
        .out       (out1),
        .out_valid (out_valid1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    localparam int NV = 19;
    vec_t vecs[NV];
    initial begin
        //         r     v     in1    in0    s     comb   out    ov
        vecs[0]  = {1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h5A, 1'b0};
        vecs[1]  = {1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[2]  = {1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b1};
        vecs[3]  = {1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[4]  = {1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b1};
        vecs[5]  = {1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[6]  = {1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[7]  = {1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[8]  = {1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[9]  = {1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[10] = {1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0};
        vecs[11] = {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0};
        vecs[12] = {1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[13] = {1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 8'hA5, 8'hA5, 1'b1};
        vecs[14] = {1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 8'h3C, 8'h3C, 1'b1};
        vecs[15] = {1'b1, 1'b1, 8'hFF, 8'h3C, 1'b1, 8'hFF, 8'h5A, 1'b0};
        vecs[16] = {1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 8'h3C, 8'h3C, 1'b1};
        vecs[17] = {1'b0, 1'b1, 8'h0F, 8'hF0, 1'b1, 8'h0F, 8'h0F, 1'b1};
        vecs[18] = {1'b0, 1'b0, 8'h0F, 8'hF0, 1'b0, 8'hF0, 8'h0F, 1'b0};
    end

    // Monitor: after each rising edge, pop the expectation queued for that edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_valid8", {7'd0, out_valid8}, {7'd0, e.valid});
                check("out8", out8, e.data);
                check("out_valid1", {7'd0, out_valid1}, {7'd0, e.valid});
                check("out1", {7'd0, out1}, {7'd0, e.data[0]});
            end
        end
    end

    initial begin
        int waited;
        rst      = 1'b1;
        in_valid = 1'b0;
        in1      = '0;
        in0      = '0;
        select   = 1'b0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst      = vecs[i].r;
            in_valid = vecs[i].v;
            in1      = vecs[i].i1;
            in0      = vecs[i].i0;
            select   = vecs[i].s;
            #1;
            check($sformatf("out_comb8[%0d]", i), out_comb8, vecs[i].comb);
            check($sformatf("out_comb1[%0d]", i), {7'd0, out_comb1}, {7'd0, vecs[i].comb[0]});
            q.push_back({vecs[i].ov, vecs[i].o});
        end
`ifdef PRIM_MUX2_XPROP_EN
        @(negedge clk);
        in_valid = 1'b0;
        select   = 1'bx;
        in1 = 8'hFF; in0 = 8'hFF; #1;
        check("xsel_11", out_comb8, 8'hFF);
        in1 = 8'h00; in0 = 8'h00; #1;
        check("xsel_00", out_comb8, 8'hxx);
        in1 = 8'hFF; in0 = 8'h00; #1;
        check("xsel_10", out_comb8, 8'hxx);
        select = 1'b0;
`endif
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        check("queue_drained", 8'(q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
